// File: rtl/simple_read_responder_pkg.sv
// -----------------------------------------------------------------------------
// simple_read_responder_pkg
// Shared memory-subsystem definitions: responder FSM state encoding,
// read/write strobe encoding, bus data width and the default response latency.
// -----------------------------------------------------------------------------
package simple_read_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } resp_state_t;

    // Encoding of mem_rd_wr
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int MEM_DW          = 32;
    localparam int DEFAULT_LATENCY = 4;

endpackage

// File: rtl/resp_mem_array.sv
// -----------------------------------------------------------------------------
// resp_mem_array
// 2^AW x 32-bit word storage: synchronous write, combinational read.
// Contents are never cleared; there is no reset input.
//
// Ports
//   clk      : clock, write happens on rising edge
//   wr_en    : write strobe
//   wr_idx   : word index to write
//   wr_data  : word to write
//   rd_idx   : word index to read
//   rd_data  : word at rd_idx (combinational)
// -----------------------------------------------------------------------------
module resp_mem_array
    import simple_read_responder_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_idx,
    input  logic [MEM_DW-1:0] wr_data,
    input  logic [AW-1:0]     rd_idx,
    output logic [MEM_DW-1:0] rd_data
);

    logic [MEM_DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/simple_read_responder.sv
// -----------------------------------------------------------------------------
// simple_read_responder
// Single-outstanding memory-mapped responder. A request inside the decoded
// window is accepted in IDLE, held for LATENCY cycles in WAIT, then answered in
// RESP for as long as the master keeps mem_en high. Writes commit on the accept
// edge and are acknowledged with the echoed write data; reads sample storage on
// the WAIT->RESP edge.
//
// Ports
//   clk            : clock
//   reset          : synchronous, active-high
//   mem_addr       : byte address (bits [1:0] ignored)
//   mem_req        : one-cycle request strobe
//   mem_en         : master holds high until it consumes the response
//   mem_rd_wr      : 1 = read, 0 = write, sampled with mem_req
//   mem_wr_data    : write data, sampled with mem_req
//   mem_data_valid : response valid / write acknowledge
//   mem_data       : read data or echoed write data; 0 when not valid
//   bus_busy_out   : registered, high whenever a transaction is in progress
// -----------------------------------------------------------------------------
module simple_read_responder
    import simple_read_responder_pkg::*;
#(
    parameter int          LATENCY   = DEFAULT_LATENCY,
    parameter int          AW        = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       mem_addr,
    input  logic              mem_req,
    input  logic              mem_en,
    input  logic              mem_rd_wr,
    input  logic [MEM_DW-1:0] mem_wr_data,
    output logic              mem_data_valid,
    output logic [MEM_DW-1:0] mem_data,
    output logic              bus_busy_out
);

    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    resp_state_t       state;
    logic [3:0]        cnt;
    logic [AW-1:0]     lat_idx;
    logic              lat_rd_wr;
    logic [MEM_DW-1:0] lat_wr_data;
    logic [MEM_DW-1:0] rd_data;
    logic              win_hit;
    logic              accept;
    logic              unused_byte_lanes;

    // Word access only: the byte-lane bits carry no meaning here.
    assign unused_byte_lanes = ^mem_addr[1:0];

    assign win_hit = (mem_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
    // Reset wins over a same-edge request, so it also blocks the storage write.
    assign accept  = !reset && (state == IDLE) && mem_req && mem_en && win_hit;

    resp_mem_array #(.AW(AW)) u_mem (
        .clk     (clk),
        .wr_en   (accept && (mem_rd_wr == RW_WRITE)),
        .wr_idx  (mem_addr[AW+1:2]),
        .wr_data (mem_wr_data),
        .rd_idx  (lat_idx),
        .rd_data (rd_data)
    );

    // Request latches are data only; they are meaningful only after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_idx     <= mem_addr[AW+1:2];
            lat_rd_wr   <= mem_rd_wr;
            lat_wr_data <= mem_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            mem_data_valid <= 1'b0;
            mem_data       <= '0;
            bus_busy_out   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state        <= WAIT;
                        cnt          <= LAT_LOAD;
                        bus_busy_out <= 1'b1;
                    end
                end
                WAIT: begin
                    // A master abort takes priority over the latency expiring.
                    if (!mem_en) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        bus_busy_out <= 1'b0;
                    end else if (cnt == '0) begin
                        state          <= RESP;
                        mem_data_valid <= 1'b1;
                        mem_data       <= (lat_rd_wr == RW_READ) ? rd_data : lat_wr_data;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (!mem_en) begin
                        state          <= IDLE;
                        mem_data_valid <= 1'b0;
                        mem_data       <= '0;
                        bus_busy_out   <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    cnt            <= '0;
                    mem_data_valid <= 1'b0;
                    mem_data       <= '0;
                    bus_busy_out   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simple_read_responder.sv
// -----------------------------------------------------------------------------
// tb_simple_read_responder
// Directed bench for simple_read_responder (LATENCY=4, AW=8, BASE_ADDR=0).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_simple_read_responder;
    import simple_read_responder_pkg::*;

    localparam int LAT = 4;

    logic        clk         = 1'b0;
    logic        reset       = 1'b1;
    logic [31:0] mem_addr    = '0;
    logic        mem_req     = 1'b0;
    logic        mem_en      = 1'b0;
    logic        mem_rd_wr   = 1'b0;
    logic [31:0] mem_wr_data = '0;
    logic        mem_data_valid;
    logic [31:0] mem_data;
    logic        bus_busy_out;

    int total = 0;
    int bad   = 0;

    simple_read_responder #(
        .LATENCY   (LAT),
        .AW        (8),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_addr       (mem_addr),
        .mem_req        (mem_req),
        .mem_en         (mem_en),
        .mem_rd_wr      (mem_rd_wr),
        .mem_wr_data    (mem_wr_data),
        .mem_data_valid (mem_data_valid),
        .mem_data       (mem_data),
        .bus_busy_out   (bus_busy_out)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_vld"},  32'(mem_data_valid), 32'd0);
        check({tag, "_data"}, mem_data,            32'd0);
        check({tag, "_busy"}, 32'(bus_busy_out),   32'd0);
    endtask

    // Present a one-cycle request and step past the accept edge.
    task automatic start(input string tag, input logic [31:0] addr, input logic rw,
                         input logic [31:0] wd);
        mem_addr    = addr;
        mem_rd_wr   = rw;
        mem_wr_data = wd;
        mem_req     = 1'b1;
        mem_en      = 1'b1;
        tick;
        mem_req = 1'b0;
        check({tag, "_busy"},  32'(bus_busy_out),   32'd1);
        check({tag, "_novld"}, 32'(mem_data_valid), 32'd0);
    endtask

    // Count edges until valid (bounded) and check latency and response word.
    task automatic wait_resp(input string tag, input int exp_lat, input logic [31:0] exp);
        int n = 0;
        do begin
            tick;
            n++;
        end while (mem_data_valid !== 1'b1 && n < 20);
        check({tag, "_lat"},  32'(n), 32'(exp_lat));
        check({tag, "_data"}, mem_data, exp);
    endtask

    // Hold the response for 'hold' cycles in total, then release mem_en.
    task automatic end_resp(input string tag, input logic [31:0] exp, input int hold);
        for (int i = 1; i < hold; i++) begin
            tick;
            check({tag, "_hold_vld"},  32'(mem_data_valid), 32'd1);
            check({tag, "_hold_data"}, mem_data,            exp);
        end
        mem_en = 1'b0;
        tick;
        check_idle({tag, "_rel"});
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        tick;
        tick;
        check_idle("reset");
        reset = 1'b0;
        tick;

        // Write then read back, write ack echoes data
        start("wr100", 32'h100, RW_WRITE, 32'hDEAD_BEEF);
        wait_resp("wr100", LAT, 32'hDEAD_BEEF);
        end_resp("wr100", 32'hDEAD_BEEF, 1);
        start("wr000", 32'h000, RW_WRITE, 32'h0BAD_F00D);
        wait_resp("wr000", LAT, 32'h0BAD_F00D);
        end_resp("wr000", 32'h0BAD_F00D, 1);
        // Byte-lane bits are ignored: 0x103 addresses word 0x100
        start("rd100", 32'h103, RW_READ, 32'h0);
        wait_resp("rd100", LAT, 32'hDEAD_BEEF);
        end_resp("rd100", 32'hDEAD_BEEF, 3);

        // Out-of-window write aliasing onto word 0 must be ignored
        mem_addr    = 32'h0000_1000;
        mem_rd_wr   = RW_WRITE;
        mem_wr_data = 32'h1234_5678;
        mem_req     = 1'b1;
        mem_en      = 1'b1;
        tick;
        mem_req = 1'b0;
        check_idle("oow_a");
        tick;
        check_idle("oow_b");
        mem_en = 1'b0;
        start("rd000", 32'h000, RW_READ, 32'h0);
        wait_resp("rd000", LAT, 32'h0BAD_F00D);
        end_resp("rd000", 32'h0BAD_F00D, 1);

        // Request with mem_en low is ignored
        mem_addr  = 32'h100;
        mem_rd_wr = RW_READ;
        mem_req   = 1'b1;
        mem_en    = 1'b0;
        tick;
        mem_req = 1'b0;
        check_idle("noen");

        // Master abort during WAIT
        start("abort", 32'h100, RW_READ, 32'h0);
        tick;
        mem_en = 1'b0;
        tick;
        check_idle("abort_a");
        for (int i = 0; i < LAT + 2; i++) begin
            tick;
            check("abort_novld", 32'(mem_data_valid), 32'd0);
        end

        // Reset in RESP, then storage survives
        start("rst", 32'h100, RW_READ, 32'h0);
        wait_resp("rst", LAT, 32'hDEAD_BEEF);
        reset = 1'b1;
        tick;
        check_idle("rst_resp");
        reset  = 1'b0;
        mem_en = 1'b0;
        tick;
        start("rst_rd", 32'h100, RW_READ, 32'h0);
        wait_resp("rst_rd", LAT, 32'hDEAD_BEEF);
        end_resp("rst_rd", 32'hDEAD_BEEF, 1);

        // Reset beats a same-edge write request
        reset       = 1'b1;
        mem_addr    = 32'h100;
        mem_rd_wr   = RW_WRITE;
        mem_wr_data = 32'hCAFE_F00D;
        mem_req     = 1'b1;
        mem_en      = 1'b1;
        tick;
        reset   = 1'b0;
        mem_req = 1'b0;
        check_idle("rst_prio");
        mem_en = 1'b0;
        tick;
        start("rst_prio_rd", 32'h100, RW_READ, 32'h0);
        wait_resp("rst_prio_rd", LAT, 32'hDEAD_BEEF);
        end_resp("rst_prio_rd", 32'hDEAD_BEEF, 1);

        // Request during WAIT is ignored
        start("wr104", 32'h104, RW_WRITE, 32'h1111_2222);
        wait_resp("wr104", LAT, 32'h1111_2222);
        end_resp("wr104", 32'h1111_2222, 1);
        start("busy_rd", 32'h100, RW_READ, 32'h0);
        tick;
        mem_addr    = 32'h104;
        mem_rd_wr   = RW_WRITE;
        mem_wr_data = 32'hFFFF_FFFF;
        mem_req     = 1'b1;
        tick;
        mem_req   = 1'b0;
        mem_addr  = 32'h100;
        mem_rd_wr = RW_READ;
        wait_resp("busy_rd", LAT - 2, 32'hDEAD_BEEF);
        end_resp("busy_rd", 32'hDEAD_BEEF, 1);
        start("rd104", 32'h104, RW_READ, 32'h0);
        wait_resp("rd104", LAT, 32'h1111_2222);
        end_resp("rd104", 32'h1111_2222, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simple_read_responder.md
SIMPLE_READ_RESPONDER -- requirements
Module: simple_read_responder

Interface
REQ-001 Parameter LATENCY, default 4, SHALL set cycles from request accept to first mem_data_valid; legal range 1..15.
REQ-002 Parameter AW, default 8, SHALL set word-index width (2^AW x 32-bit storage).
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, SHALL set the decoded window base; the window is 2^(AW+2) bytes.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  reset is synchronous and active-high.
REQ-006 mem_addr  input  32  byte address from bus master.
REQ-007 mem_req  input  1  one-cycle request strobe from master.
REQ-008 mem_en  input  1  master holds high from request until it consumes the response.
REQ-009 mem_rd_wr  input  1  1 = read, 0 = write; sampled with mem_req.
REQ-010 mem_wr_data  input  32  write data; sampled with mem_req.
REQ-011 mem_data_valid  output  1  response valid / write acknowledge.
REQ-012 mem_data  output  32  read data, or echoed write data on write ack.
REQ-013 bus_busy_out  output  1  transaction in progress; other masters must not request.

Function
REQ-014 States SHALL be IDLE, WAIT, RESP.
REQ-015 Accept SHALL occur in IDLE when mem_req=1, mem_en=1 and mem_addr[31:AW+2] == BASE_ADDR[31:AW+2].
REQ-016 On accept: latch mem_addr[AW+1:2], mem_rd_wr and mem_wr_data; load latency counter with LATENCY-1; go to WAIT.
REQ-017 Write SHALL commit to storage on the accept edge; read data SHALL be sampled from storage on the WAIT->RESP edge.
REQ-018 Out-of-window requests, and requests with mem_en=0, SHALL be ignored: no state change, no busy.
REQ-019 mem_req during WAIT or RESP SHALL be ignored (no re-latch, no storage write).
REQ-020 WAIT: counter decrements each cycle; at counter==0 go to RESP, so mem_data_valid first rises exactly LATENCY cycles after the accept edge.
REQ-021 RESP: mem_data_valid=1 and mem_data stable, held every cycle while mem_en=1.
REQ-022 RESP with mem_en=0: return to IDLE next edge; mem_data_valid=0 from that edge.
REQ-023 WAIT with mem_en=0 (master abort): return to IDLE next edge, no response; an already committed write stays committed.
REQ-024 bus_busy_out SHALL equal (state != IDLE); registered, no combinational path from inputs.
REQ-025 mem_data SHALL be 0 whenever mem_data_valid=0.
REQ-026 Back-to-back: a new accept is possible on the edge following the return to IDLE (one idle cycle minimum between transactions).
REQ-027 Address bits [1:0] SHALL be ignored; no byte enables, full-word access only.

Reset
REQ-028 reset=1 at a rising edge SHALL force IDLE, counter=0, mem_data_valid=0, mem_data=0, bus_busy_out=0, including mid-WAIT or mid-RESP.
REQ-029 Storage contents SHALL NOT be cleared by reset.
REQ-030 reset SHALL have priority over mem_req on the same edge.

Structure
REQ-031 State encoding (IDLE=2'b00, WAIT=2'b01, RESP=2'b10), read/write encoding and default LATENCY SHALL live in the shared memory-subsystem package.
REQ-032 Storage SHALL be a separate sub-module, resp_mem_array: 2^AW x 32, synchronous write, combinational read.
REQ-033 Control FSM, counter and latches SHALL reside in simple_read_responder.

Verification
REQ-034 Write 0x100=0xDEADBEEF, then read 0x100 with LATENCY=4 -> ack 4 cycles after each accept; read returns 0xDEADBEEF; busy high from accept+1 until release.
REQ-035 Read, master holds mem_en 3 cycles into RESP -> mem_data_valid and mem_data stable for 3 cycles, drop to 0 the edge after mem_en falls.
REQ-036 Request at 0x0000_1000 with BASE_ADDR=0, AW=8 -> no busy, no valid, storage unchanged.
REQ-037 Read accepted, mem_en dropped at accept+2 -> IDLE next edge, mem_data_valid never asserts.
REQ-038 reset asserted in RESP -> next edge all outputs 0, state IDLE; subsequent read of previously written word returns the stored value.
REQ-039 mem_req pulse to 0x104 during WAIT of a read of 0x100 -> ignored; response returns 0x100 data; 0x104 unchanged.
